// File: rtl/me_frame_scheduler_if.sv
// Result slot handshake between the ME frame scheduler and its consumer.
interface me_frame_scheduler_if;
   logic        res_valid;
   logic        res_ready;
   logic [8:0]  res_mb_x;
   logic [8:0]  res_mb_y;
   logic [13:0] res_sad;
   logic [3:0]  res_mv_x;
   logic [3:0]  res_mv_y;

   modport master (
      output res_valid, res_mb_x, res_mb_y, res_sad, res_mv_x, res_mv_y,
      input  res_ready
   );

   modport slave (
      input  res_valid, res_mb_x, res_mb_y, res_sad, res_mv_x, res_mv_y,
      output res_ready
   );
endinterface

// File: rtl/me_frame_scheduler.sv
// Sequences the 25-cycle ME core across a frame of 8x8 macroblocks in raster order,
// issuing phase-aligned row reads and holding each result in a 1-deep valid/ready slot.
module me_frame_scheduler #(
   parameter int unsigned MB_COLS = 480,
   parameter int unsigned MB_ROWS = 270,
   parameter int unsigned RD_LAT  = 1,
   parameter int unsigned ADDR_W  = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_core_rst_n,
   output logic              o_crt_rd_en,
   output logic [ADDR_W-1:0] o_crt_rd_addr,
   output logic              o_ref_rd_en,
   output logic [ADDR_W-1:0] o_ref_rd_addr,
   input  logic              i_core_sad_en,
   input  logic [13:0]       i_core_sad_min,
   input  logic [3:0]        i_core_mv_x,
   input  logic [3:0]        i_core_mv_y,
   me_frame_scheduler_if.master res_if
);

   typedef enum logic [2:0] {StIdle, StPrime, StRun, StDrain, StDone} state_e;

   localparam logic [4:0] DecPh   = 5'(24 - RD_LAT);
   localparam logic [4:0] PrimeEnd = 5'(RD_LAT - 1);
   localparam logic [8:0] LastX   = 9'(MB_COLS - 1);
   localparam logic [8:0] LastY   = 9'(MB_ROWS - 1);

   state_e      r_state;
   logic [4:0]  r_ph;
   logic [8:0]  r_rd_x, r_rd_y;
   logic [8:0]  r_cmp_x, r_cmp_y;
   logic        r_cmp_disc;
   logic        r_first;
   logic        r_core_rst_n;
   logic        r_done;
   logic        r_valid;
   logic [8:0]  r_res_x, r_res_y;
   logic [13:0] r_res_sad;
   logic [3:0]  r_res_mv_x, r_res_mv_y;

   logic [5:0]        w_sum;
   logic [4:0]        w_sum_m;
   logic              w_wrap;
   logic [4:0]        w_c;
   logic              w_act;
   logic              w_crt_en, w_ref_en;
   int                w_crt_row, w_ref_row;
   logic [ADDR_W-1:0] w_crt_addr, w_ref_addr;

   // Consume phase: the core phase at which the data issued now reaches the core.
   assign w_sum   = {1'b0, r_ph} + 6'(RD_LAT);
   assign w_wrap  = (w_sum >= 6'd25);
   assign w_sum_m = 5'(w_sum - 6'd25);

   always_comb begin
      w_c   = r_ph;
      w_act = 1'b0;
      case (r_state)
         StPrime: begin
            w_c   = r_ph;
            w_act = 1'b1;
         end
         StRun: begin
            w_c   = w_wrap ? w_sum_m : w_sum[4:0];
            w_act = 1'b1;
         end
         StDrain: begin
            w_c   = w_sum[4:0];
            w_act = !w_wrap;
         end
         default: ;
      endcase
   end

   // r_rd_* already holds the next block once the advance decision has been taken.
   always_comb begin
      w_crt_row = int'(r_rd_y) * 8 + int'(w_c);
      w_ref_row = int'(r_rd_y) * 8 + int'(w_c) - 10;
      if (w_ref_row < 0) begin
         w_ref_row = 0;
      end else if (w_ref_row > int'(MB_ROWS) * 8 - 1) begin
         w_ref_row = int'(MB_ROWS) * 8 - 1;
      end
      w_crt_addr = ADDR_W'(w_crt_row * int'(MB_COLS) + int'(r_rd_x));
      w_ref_addr = ADDR_W'(w_ref_row * int'(MB_COLS) + int'(r_rd_x));
   end

   assign w_crt_en = w_act && (w_c < 5'd8);
   assign w_ref_en = w_act && (w_c >= 5'd2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StIdle;
         r_ph         <= '0;
         r_rd_x       <= '0;
         r_rd_y       <= '0;
         r_cmp_x      <= '0;
         r_cmp_y      <= '0;
         r_cmp_disc   <= 1'b0;
         r_first      <= 1'b0;
         r_core_rst_n <= 1'b0;
         r_done       <= 1'b0;
         r_valid      <= 1'b0;
         r_res_x      <= '0;
         r_res_y      <= '0;
         r_res_sad    <= '0;
         r_res_mv_x   <= '0;
         r_res_mv_y   <= '0;
      end else begin
         r_done <= 1'b0;
         if (r_valid && res_if.res_ready) begin
            r_valid <= 1'b0;
         end
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_state    <= StPrime;
                  r_ph       <= '0;
                  r_rd_x     <= '0;
                  r_rd_y     <= '0;
                  r_cmp_disc <= 1'b0;
               end
            end
            StPrime: begin
               if (r_ph == PrimeEnd) begin
                  r_state      <= StRun;
                  r_ph         <= '0;
                  r_core_rst_n <= 1'b1;
                  r_first      <= 1'b1;
               end else begin
                  r_ph <= r_ph + 5'd1;
               end
            end
            StRun, StDrain: begin
               r_ph <= (r_ph == 5'd24) ? 5'd0 : r_ph + 5'd1;
               if (r_ph == 5'd0) begin
                  if (i_core_sad_en && !r_first && !r_cmp_disc) begin
                     r_valid    <= 1'b1;
                     r_res_x    <= r_cmp_x;
                     r_res_y    <= r_cmp_y;
                     r_res_sad  <= i_core_sad_min;
                     r_res_mv_x <= i_core_mv_x;
                     r_res_mv_y <= i_core_mv_y;
                  end
                  r_first    <= 1'b0;
                  r_cmp_x    <= r_rd_x;
                  r_cmp_y    <= r_rd_y;
                  r_cmp_disc <= 1'b0;
                  if (r_state == StDrain) begin
                     if (r_cmp_disc) begin
                        r_state <= StRun;
                     end else begin
                        r_state      <= StDone;
                        r_core_rst_n <= 1'b0;
                        r_done       <= 1'b1;
                     end
                  end
               end
               // A full slot that is not draining forces a replay of the block in flight.
               if (r_state == StRun && r_ph == DecPh) begin
                  if (!r_valid || res_if.res_ready) begin
                     if (r_rd_x == LastX) begin
                        if (r_rd_y == LastY) begin
                           r_state <= StDrain;
                        end else begin
                           r_rd_x <= '0;
                           r_rd_y <= r_rd_y + 9'd1;
                        end
                     end else begin
                        r_rd_x <= r_rd_x + 9'd1;
                     end
                  end else begin
                     r_cmp_disc <= 1'b1;
                  end
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_busy        = (r_state != StIdle);
   assign o_done        = r_done;
   assign o_core_rst_n  = r_core_rst_n;
   assign o_crt_rd_en   = w_crt_en;
   assign o_crt_rd_addr = w_crt_en ? w_crt_addr : '0;
   assign o_ref_rd_en   = w_ref_en;
   assign o_ref_rd_addr = w_ref_en ? w_ref_addr : '0;

   assign res_if.res_valid = r_valid;
   assign res_if.res_mb_x  = r_res_x;
   assign res_if.res_mb_y  = r_res_y;
   assign res_if.res_sad   = r_res_sad;
   assign res_if.res_mv_x  = r_res_mv_x;
   assign res_if.res_mv_y  = r_res_mv_y;

endmodule
